// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed seven-segment driver: one guarded slot per digit, with
// per-digit blink, decimal points, hours-tens zero blanking and a dash for non-BCD codes.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4,
    parameter int BLINK_SCANS = 83
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [23:0] digits,
    input  logic [5:0]  blink_mask,
    input  logic [5:0]  dp_mask,
    input  logic        lz_blank,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    // state | meaning
    // BLANK | guard interval, every anode off; cur is latched at pcnt==0
    // ON    | digit idx is driven unless blinked off or zero-blanked
    typedef enum logic {BLANK, ON} state_t;

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [PW-1:0] PCNT_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD - 1);
    localparam logic [SW-1:0] SCNT_LAST  = SW'(BLINK_SCANS - 1);

    state_t        st, st_nx;
    logic [PW-1:0] pcnt, pcnt_nx;
    logic [2:0]    idx, idx_nx;
    logic [SW-1:0] scnt, scnt_nx;
    logic          bph, bph_nx;
    logic [3:0]    cur, cur_nx;
    logic [5:0]    an_nx;
    logic [6:0]    seg_nx;
    logic          dp_nx;
    logic          suppressed;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        st_nx   = st;
        pcnt_nx = pcnt;
        idx_nx  = idx;
        scnt_nx = scnt;
        bph_nx  = bph;
        cur_nx  = cur;
        an_nx   = 6'b111111;
        seg_nx  = 7'h7F;
        dp_nx   = 1'b1;
        suppressed = (!bph && blink_mask[idx]) ||
                     (idx == 3'd5 && lz_blank && cur == 4'd0);

        if (!en) begin
            // Re-enable restarts the slot anyway, so parking at its start is
            // indistinguishable from freezing and makes the relatch automatic.
            st_nx   = BLANK;
            pcnt_nx = '0;
        end else begin
            if (st == BLANK && pcnt == '0)
                cur_nx = digits[{idx, 2'b00} +: 4];

            if (st == ON && !suppressed) begin
                an_nx  = ~(6'b000001 << idx);
                seg_nx = decode(cur);
                dp_nx  = ~dp_mask[idx];
            end

            if (pcnt == PCNT_LAST) begin
                pcnt_nx = '0;
                st_nx   = BLANK;
                if (idx == 3'd5) begin
                    idx_nx = '0;
                    if (scnt == SCNT_LAST) begin
                        scnt_nx = '0;
                        bph_nx  = ~bph;
                    end else begin
                        scnt_nx = scnt + 1'b1;
                    end
                end else begin
                    idx_nx = idx + 3'd1;
                end
            end else begin
                pcnt_nx = pcnt + 1'b1;
                if (st == BLANK && pcnt == GUARD_LAST)
                    st_nx = ON;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st   <= BLANK;
            pcnt <= '0;
            idx  <= '0;
            scnt <= '0;
            bph  <= 1'b1;
            cur  <= '0;
            an   <= 6'b111111;
            seg  <= 7'h7F;
            dp   <= 1'b1;
        end else begin
            st   <= st_nx;
            pcnt <= pcnt_nx;
            idx  <= idx_nx;
            scnt <= scnt_nx;
            bph  <= bph_nx;
            cur  <= cur_nx;
            an   <= an_nx;
            seg  <= seg_nx;
            dp   <= dp_nx;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with an 8-cycle slot, 2-cycle guard and
// 2-scan blink half-period; expected frames come from hand-entered glyph tables.
module tb_seg7_scan_driver;
    localparam int RD = 8;
    localparam int GD = 2;
    localparam int BS = 2;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        en = 1'b1;
    logic [23:0] digits = 24'h235947;
    logic [5:0]  blink_mask = '0;
    logic [5:0]  dp_mask = '0;
    logic        lz_blank = 1'b0;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_chk = 0;
    int n_err = 0;
    int t = 0;

    logic [6:0] exp_seg [6];
    logic [5:0] exp_dark = '0;
    logic [5:0] exp_blk = '0;
    logic [5:0] exp_dp = '0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD), .BLINK_SCANS(BS)) dut (
        .clk(clk), .clr(clr), .en(en), .digits(digits),
        .blink_mask(blink_mask), .dp_mask(dp_mask), .lz_blank(lz_blank),
        .an(an), .seg(seg), .dp(dp)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_segs(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5);
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2;
        exp_seg[3] = s3; exp_seg[4] = s4; exp_seg[5] = s5;
    endtask

    // t is the cycle (since the slot-0 epoch) whose state the next edge registers.
    task automatic run(input int n);
        int slot;
        int p;
        logic vis;
        logic lit;
        logic [13:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            slot = (t / RD) % 6;
            p    = t % RD;
            vis  = ((t / (6 * RD * BS)) % 2) == 0;
            lit  = (p >= GD) && !exp_dark[slot] && !(exp_blk[slot] && !vis);
            e = lit ? {~(6'b000001 << slot), exp_seg[slot], ~exp_dp[slot]}
                    : {6'b111111, 7'h7F, 1'b1};
            check($sformatf("frame t=%0d", t), {2'b00, an, seg, dp}, {2'b00, e});
            t++;
        end
    endtask

    task automatic run_off(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("en_off %0d", i), {2'b00, an, seg, dp}, {2'b00, 6'b111111, 7'h7F, 1'b1});
        end
    endtask

    initial begin
        // 2 3 5 9 4 7 : idx0=7 idx1=4 idx2=9 idx3=5 idx4=3 idx5=2
        load_segs(7'b1111000, 7'b0011001, 7'b0010000, 7'b0010010, 7'b0110000, 7'b0100100);
        #1 clr = 1'b1;
        #1;
        check("rst_an", {10'd0, an}, {10'd0, 6'b111111});
        check("rst_seg", {9'd0, seg}, {9'd0, 7'h7F});
        check("rst_dp", {15'd0, dp}, 16'd1);
        #1 clr = 1'b0;
        t = 0;
        run(96);
        run(21);

        // Asynchronous clear in the middle of slot 2's lit window.
        #1 clr = 1'b1;
        #1;
        check("clr_an", {10'd0, an}, {10'd0, 6'b111111});
        check("clr_seg", {9'd0, seg}, {9'd0, 7'h7F});
        check("clr_dp", {15'd0, dp}, 16'd1);
        #1 clr = 1'b0;
        t = 0;
        run(48);

        // 0 A 1 2 3 4 with hours-tens blanked, then shown.
        digits = 24'h0A1234;
        lz_blank = 1'b1;
        load_segs(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b0111111, 7'b1000000);
        exp_dark = 6'b100000;
        run(48);
        lz_blank = 1'b0;
        exp_dark = 6'b000000;
        run(48);

        // Blink on slots 0-1, decimal point on slot 2; t=144 is an invisible scan.
        blink_mask = 6'b000011;
        dp_mask = 6'b000100;
        exp_blk = 6'b000011;
        exp_dp = 6'b000100;
        run(192);

        // Seconds units change mid-slot 0 must wait for the next scan.
        blink_mask = '0;
        dp_mask = '0;
        exp_blk = '0;
        exp_dp = '0;
        digits = 24'h0A1233;
        exp_seg[0] = 7'b0110000;
        run(4);
        digits = 24'h0A1238;
        run(44);
        exp_seg[0] = 7'b0000000;
        run(48);

        // Freeze during slot 3; blink on slot 3 exposes any drift in scnt/bph.
        blink_mask = 6'b001000;
        exp_blk = 6'b001000;
        run(27);
        en = 1'b0;
        run_off(20);
        en = 1'b1;
        t = t - (t % RD);
        run(144);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
